prog_mem: RTL and testbench

Writable program memory that answers the CPU's instruction fetch: for each CPU address it returns the 4-bit opcode and 4-bit immediate. It also contains a bit-serial loader, so a program can be shifted in from a debug/host pin without resynthesis. While a load is in progress, the block holds the CPU out of execution through `cpu_run`, which the top level ANDs into the CPU's `n_rst`.

---
 rtl/prog_mem_if.sv | 49 ++++
 rtl/prog_mem.sv | 144 ++++++++++++++
 tb/tb_prog_mem.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_if.sv
// prog_mem_if: groups the CPU fetch port and the serial loader port of prog_mem.
//   master modport: CPU/host side (drives addr, load_req, bit_valid, bit_in)
//   slave modport : memory side  (drives opecode, imm, cpu_run, load_done, words_loaded)
// Signals:
//   addr         CPU fetch address
//   opecode/imm  fetched instruction fields
//   load_req     level request to load a program
//   bit_valid    qualifies bit_in
//   bit_in       serial program data, MSB first
//   cpu_run      1 allows the CPU to execute
//   load_done    one-cycle pulse when a load ends
//   words_loaded complete words written by the most recent load
interface prog_mem_if #(
  parameter int unsigned ADDR_W = 4
) ();
  logic [ADDR_W-1:0] addr;
  logic [3:0]        opecode;
  logic [3:0]        imm;
  logic              load_req;
  logic              bit_valid;
  logic              bit_in;
  logic              cpu_run;
  logic              load_done;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output addr,
    output load_req,
    output bit_valid,
    output bit_in,
    input  opecode,
    input  imm,
    input  cpu_run,
    input  load_done,
    input  words_loaded
  );

  modport slave (
    input  addr,
    input  load_req,
    input  bit_valid,
    input  bit_in,
    output opecode,
    output imm,
    output cpu_run,
    output load_done,
    output words_loaded
  );
endinterface

// File: rtl/prog_mem.sv
// prog_mem: writable program memory with a bit-serial loader.
//   Fetch: {opecode,imm} = mem[addr] combinationally while running; forced to 0 while loading.
//   Load : a rising edge on load_req enters LOAD; 8 qualified bits (MSB first) form one word,
//          written at the write pointer. The load ends when load_req drops or when the last
//          word of the memory is written. cpu_run holds the CPU in reset while loading.
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset (clears memory, returns to RUN, cpu_run low)
//   bus    prog_mem_if slave modport (fetch + loader signals)
module prog_mem #(
  parameter int unsigned ADDR_W = 4
) (
  input logic         clk,
  input logic         n_rst,
  prog_mem_if.slave   bus
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] WptrLast = ADDR_W'(Depth - 1);
  localparam logic [ADDR_W:0]   WordsOne = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] WptrOne  = ADDR_W'(1);

  typedef enum logic {
    StRun  = 1'b0,
    StLoad = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              load_req_q;
  logic [7:0]        mem_q [Depth];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  // Only the 7 earlier bits of a word need storing; the 8th comes straight from bit_in.
  logic [6:0]        sreg_q, sreg_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              cpu_run_q, cpu_run_d;
  logic              load_done_q, load_done_d;

  logic              start;
  logic              bit_fire;
  logic              word_done;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        rd_word;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    start     = (state_q == StRun) && bus.load_req && !load_req_q;
    bit_fire  = (state_q == StLoad) && bus.bit_valid;
    word_done = bit_fire && (bitcnt_q == 3'd7);
    mem_we    = word_done;
    mem_wdata = {sreg_q, bus.bit_in};

    state_d  = state_q;
    wptr_d   = wptr_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    words_d  = words_q;

    unique case (state_q)
      StRun: begin
        if (start) begin
          state_d  = StLoad;
          wptr_d   = '0;
          bitcnt_d = '0;
          sreg_d   = '0;
          words_d  = '0;
        end
      end
      StLoad: begin
        if (bit_fire) begin
          sreg_d   = {sreg_q[5:0], bus.bit_in};
          // 3-bit counter wraps 7 -> 0 exactly when a word completes.
          bitcnt_d = bitcnt_q + 3'd1;
        end
        if (word_done) begin
          wptr_d  = wptr_q + WptrOne;
          words_d = words_q + WordsOne;
        end
        // A word completing as load_req falls is still written (mem_we above), then we exit.
        if (!bus.load_req || (word_done && (wptr_q == WptrLast))) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    cpu_run_d   = (state_d == StRun);
    load_done_d = (state_q == StLoad) && (state_d == StRun);
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StRun;
      load_req_q  <= 1'b0;
      wptr_q      <= '0;
      bitcnt_q    <= '0;
      sreg_q      <= '0;
      words_q     <= '0;
      cpu_run_q   <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_req_q  <= bus.load_req;
      wptr_q      <= wptr_d;
      bitcnt_q    <= bitcnt_d;
      sreg_q      <= sreg_d;
      words_q     <= words_d;
      cpu_run_q   <= cpu_run_d;
      load_done_q <= load_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: reset clears every word to 0x00 (ADD A,0, a no-op)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem_q[wptr_q] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_word = mem_q[bus.addr];

  // The CPU is held in reset during LOAD, but fetch outputs are still zeroed for safety.
  assign bus.opecode      = (state_q == StLoad) ? 4'h0 : rd_word[7:4];
  assign bus.imm          = (state_q == StLoad) ? 4'h0 : rd_word[3:0];
  assign bus.cpu_run      = cpu_run_q;
  assign bus.load_done    = load_done_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: randomized self-checking bench for prog_mem.
// Stimulus pushes expected fetch results and expected load completions into queues;
// a negedge monitor pops and compares whenever a read is strobed or load_done appears.
module tb_prog_mem;

  localparam int unsigned ADDR_W = 4;
  localparam int Depth = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  prog_mem_if #(.ADDR_W(ADDR_W)) bus ();

  prog_mem #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  logic [7:0] model_mem [Depth];
  logic [7:0] exp_rd_q [$];
  int         exp_done_q [$];
  logic       rd_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares DUT presentations against queued expectations.
  always @(negedge clk) begin
    if (n_rst) begin
      if (rd_strobe) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: read strobe with empty queue at %0t", $time);
        end else begin
          logic [7:0] e;
          e = exp_rd_q.pop_front();
          check("rd_opecode", 32'(bus.opecode), 32'(e[7:4]));
          check("rd_imm", 32'(bus.imm), 32'(e[3:0]));
        end
      end
      if (bus.load_done) begin
        done_seen++;
        if (exp_done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL done_unexpected: load_done with words_loaded %0d at %0t",
                   bus.words_loaded, $time);
        end else begin
          int ew;
          ew = exp_done_q.pop_front();
          check("done_words", 32'(bus.words_loaded), ew);
          check("done_cpu_run", 32'(bus.cpu_run), 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input int a, input bit in_load);
    bus.addr = ADDR_W'(a);
    exp_rd_q.push_back(in_load ? 8'h00 : model_mem[a]);
    rd_strobe = 1'b1;
    @(negedge clk);
    #1;
    rd_strobe = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < Depth; a++) read_chk(a, 1'b0);
  endtask

  task automatic start_load(input int exp_words, input bit push);
    bus.load_req = 1'b1;
    tick();
    check("start_cpu_run", 32'(bus.cpu_run), 32'd0);
    if (push) exp_done_q.push_back(exp_words);
  endtask

  task automatic send_bit(input logic b, input bit gap);
    if (gap) begin
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'($urandom);
      tick();
    end
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    tick();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'($urandom);
  endtask

  task automatic send_word(input logic [7:0] w, input bit gap);
    for (int i = 7; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic end_load();
    bus.load_req = 1'b0;
    tick();
    check("exit_cpu_run", 32'(bus.cpu_run), 32'd1);
    check("exit_load_done", 32'(bus.load_done), 32'd1);
    tick();
    check("done_pulse_end", 32'(bus.load_done), 32'd0);
  endtask

  task automatic clear_model(input logic [7:0] v);
    for (int i = 0; i < Depth; i++) model_mem[i] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    logic [7:0] w;
    logic [7:0] words [4];
    bit gap;

    bus.addr      = '0;
    bus.load_req  = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    clear_model(8'h00);

    // Reset: outputs zero and CPU held for every address.
    for (int a = 0; a < Depth; a++) begin
      bus.addr = ADDR_W'(a);
      #1;
      check("rst_opecode", 32'(bus.opecode), 32'd0);
      check("rst_imm", 32'(bus.imm), 32'd0);
      check("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    end
    check("rst_load_done", 32'(bus.load_done), 32'd0);
    check("rst_words", 32'(bus.words_loaded), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    check("rel_cpu_run_pre", 32'(bus.cpu_run), 32'd0);
    tick();
    check("rel_cpu_run", 32'(bus.cpu_run), 32'd1);
    read_all();

    // Two-word load.
    d0 = done_seen;
    start_load(2, 1'b1);
    send_word(8'h3A, 1'b0);
    send_word(8'hB5, 1'b0);
    end_load();
    model_mem[0] = 8'h3A;
    model_mem[1] = 8'hB5;
    check("two_words", 32'(bus.words_loaded), 32'd2);
    check("two_done_count", done_seen - d0, 32'd1);
    read_chk(0, 1'b0);
    read_chk(1, 1'b0);
    read_chk(2, 1'b0);

    // Random loads of 1..4 words, optionally gapped.
    for (int t = 0; t < 3; t++) begin
      n   = int'($urandom_range(1, 4));
      gap = 1'($urandom);
      start_load(n, 1'b1);
      for (int k = 0; k < n; k++) begin
        words[k] = 8'($urandom);
        send_word(words[k], gap);
      end
      end_load();
      for (int k = 0; k < n; k++) model_mem[k] = words[k];
      check("rand_words", 32'(bus.words_loaded), n);
      read_all();
    end

    // Gapped bits with the same two words.
    start_load(2, 1'b1);
    send_word(8'h3A, 1'b1);
    send_word(8'hB5, 1'b1);
    end_load();
    model_mem[0] = 8'h3A;
    model_mem[1] = 8'hB5;
    check("gap_words", 32'(bus.words_loaded), 32'd2);
    read_all();

    // Full load, load_req held high; exits after the last word.
    d0 = done_seen;
    start_load(Depth, 1'b1);
    for (int k = 0; k < Depth; k++) send_word(8'(k), 1'b0);
    check("full_exit_cpu_run", 32'(bus.cpu_run), 32'd1);
    check("full_exit_done", 32'(bus.load_done), 32'd1);
    for (int k = 0; k < Depth; k++) model_mem[k] = 8'(k);
    send_word(8'($urandom), 1'b0);
    check("full_words", 32'(bus.words_loaded), 32'd16);
    check("full_cpu_run_extra", 32'(bus.cpu_run), 32'd1);
    read_all();
    for (int k = 0; k < 3; k++) tick();
    check("full_no_restart", 32'(bus.cpu_run), 32'd1);
    check("full_done_count", done_seen - d0, 32'd1);

    // Re-arm: low then high starts a new load (preload with 0xFF).
    bus.load_req = 1'b0;
    tick();
    start_load(Depth, 1'b1);
    for (int k = 0; k < Depth; k++) send_word(8'hFF, 1'b0);
    clear_model(8'hFF);
    bus.load_req = 1'b0;
    tick();
    tick();
    check("ff_words", 32'(bus.words_loaded), 32'd16);

    // Partial word over 0xFF memory; outputs forced to 0 during LOAD.
    start_load(2, 1'b1);
    read_chk(2, 1'b1);
    words[0] = 8'($urandom);
    words[1] = 8'($urandom);
    send_word(words[0], 1'b0);
    send_word(words[1], 1'b0);
    for (int k = 0; k < 5; k++) send_bit(1'($urandom), 1'b0);
    end_load();
    model_mem[0] = words[0];
    model_mem[1] = words[1];
    check("part_words", 32'(bus.words_loaded), 32'd2);
    read_all();

    // Word completes on the same edge load_req falls: still written, then exit.
    w = 8'($urandom);
    start_load(1, 1'b1);
    for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
    bus.load_req  = 1'b0;
    bus.bit_valid = 1'b1;
    bus.bit_in    = w[0];
    tick();
    bus.bit_valid = 1'b0;
    check("coinc_cpu_run", 32'(bus.cpu_run), 32'd1);
    check("coinc_done", 32'(bus.load_done), 32'd1);
    tick();
    model_mem[0] = w;
    check("coinc_words", 32'(bus.words_loaded), 32'd1);
    read_chk(0, 1'b0);
    read_chk(1, 1'b0);

    // Reset mid-load after 3 bits of the 2nd word.
    d0 = done_seen;
    start_load(0, 1'b0);
    send_word(8'($urandom), 1'b0);
    for (int k = 0; k < 3; k++) send_bit(1'($urandom), 1'b0);
    n_rst = 1'b0;
    #1;
    check("mid_rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    check("mid_rst_done", 32'(bus.load_done), 32'd0);
    bus.load_req = 1'b0;
    for (int a = 0; a < Depth; a += 5) begin
      bus.addr = ADDR_W'(a);
      #1;
      check("mid_rst_opecode", 32'(bus.opecode), 32'd0);
      check("mid_rst_imm", 32'(bus.imm), 32'd0);
    end
    clear_model(8'h00);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    tick();
    check("mid_rel_cpu_run", 32'(bus.cpu_run), 32'd1);
    check("mid_rel_words", 32'(bus.words_loaded), 32'd0);
    read_all();
    check("mid_no_done", done_seen - d0, 32'd0);

    check("done_queue_empty", exp_done_q.size(), 32'd0);
    check("rd_queue_empty", exp_rd_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
